// File: rtl/wb_pkg.sv
// Shared Wishbone definitions.
//   - Default bus geometry (address, data, byte-select widths), shared with
//     wishbone_master so both ends of the bus agree.
//   - State encoding of the round-robin bus arbiter.
package wb_pkg;

    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;

    typedef enum logic [1:0] {
        WB_ARB_IDLE = 2'd0,
        WB_ARB_BUSY = 2'd1,
        WB_ARB_ERR  = 2'd2
    } wb_arb_state_e;

endpackage

// File: rtl/wb_rr_arbiter_if.sv
// Bundle of every bus signal around the round-robin arbiter.
//   Master side : m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i (packed,
//                 master k at [k*W +: W]); m_ack_o, m_err_o, m_dat_o, gnt_o.
//   Slave side  : cyc_o, stb_o, we_o, sel_o, adr_o, dat_o; ack_i, dat_i.
// Modport 'slave' is the arbiter's own view (it is the slave of the masters).
// Modport 'master' is the view of whatever surrounds it: the requesting
// masters together with the downstream slave.
interface wb_rr_arbiter_if
    import wb_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int ADR_W       = WB_ADR_W,
    parameter int DAT_W       = WB_DAT_W,
    parameter int SEL_W       = WB_SEL_W
) ();

    logic [NUM_MASTERS-1:0]       m_cyc_i;
    logic [NUM_MASTERS-1:0]       m_stb_i;
    logic [NUM_MASTERS-1:0]       m_we_i;
    logic [NUM_MASTERS*SEL_W-1:0] m_sel_i;
    logic [NUM_MASTERS*ADR_W-1:0] m_adr_i;
    logic [NUM_MASTERS*DAT_W-1:0] m_dat_i;
    logic [NUM_MASTERS-1:0]       m_ack_o;
    logic [NUM_MASTERS-1:0]       m_err_o;
    logic [DAT_W-1:0]             m_dat_o;
    logic [NUM_MASTERS-1:0]       gnt_o;

    logic                         cyc_o;
    logic                         stb_o;
    logic                         we_o;
    logic [SEL_W-1:0]             sel_o;
    logic [ADR_W-1:0]             adr_o;
    logic [DAT_W-1:0]             dat_o;
    logic                         ack_i;
    logic [DAT_W-1:0]             dat_i;

    modport slave (
        input  m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i, ack_i, dat_i,
        output m_ack_o, m_err_o, m_dat_o, gnt_o,
               cyc_o, stb_o, we_o, sel_o, adr_o, dat_o
    );

    modport master (
        output m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i, ack_i, dat_i,
        input  m_ack_o, m_err_o, m_dat_o, gnt_o,
               cyc_o, stb_o, we_o, sel_o, adr_o, dat_o
    );

endinterface

// File: rtl/wb_rr_pick.sv
// Combinational round-robin priority picker.
//   req    : request vector, one bit per master.
//   rr_ptr : index that has highest priority this round (must be < NUM_MASTERS).
//   gnt    : one-hot winner (first requester scanning rr_ptr, rr_ptr+1, ...).
//   vld    : high when any request is present.
module wb_rr_pick #(
    parameter int NUM_MASTERS = 4
) (
    input  logic [NUM_MASTERS-1:0]         req,
    input  logic [$clog2(NUM_MASTERS)-1:0] rr_ptr,
    output logic [NUM_MASTERS-1:0]         gnt,
    output logic                           vld
);

    localparam int PTR_W  = $clog2(NUM_MASTERS);
    localparam int SLOT_W = PTR_W + 1;

    // One extra bit so rr_ptr + i never overflows before the modulo fold.
    logic [SLOT_W-1:0] slot;

    always_comb begin
        gnt  = '0;
        vld  = 1'b0;
        slot = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            slot = {1'b0, rr_ptr} + SLOT_W'(i);
            if (slot >= SLOT_W'(NUM_MASTERS)) begin
                slot = slot - SLOT_W'(NUM_MASTERS);
            end
            if (!vld && req[slot[PTR_W-1:0]]) begin
                gnt[slot[PTR_W-1:0]] = 1'b1;
                vld                  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: shares one slave bus among NUM_MASTERS masters.
// Grants whole bus cycles (held while the owner keeps cyc high), muxes the
// owner's controls to the slave, routes ack back to the owner only, and aborts
// a strobe that waits TIMEOUT cycles without ack via a one-cycle m_err_o pulse.
//   clk_i : rising-edge clock.
//   rst_i : synchronous reset, active-low.
//   bus   : wb_rr_arbiter_if.slave, all master-side and slave-side signals.
module wb_rr_arbiter
    import wb_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int ADR_W       = WB_ADR_W,
    parameter int DAT_W       = WB_DAT_W,
    parameter int SEL_W       = WB_SEL_W,
    parameter int TIMEOUT     = 255
) (
    input  logic           clk_i,
    input  logic           rst_i,
    wb_rr_arbiter_if.slave bus
);

    localparam int PTR_W = $clog2(NUM_MASTERS);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    wb_arb_state_e          state_q;
    logic [NUM_MASTERS-1:0] gnt_q;
    logic [PTR_W-1:0]       owner_q;
    logic [PTR_W-1:0]       rr_ptr_q;
    logic [CNT_W-1:0]       wd_cnt_q;

    logic [NUM_MASTERS-1:0] pick_gnt;
    logic                   pick_vld;

    logic                   busy;
    logic                   own_cyc;
    logic                   own_stb;
    logic                   cyc_mux;
    logic                   stb_mux;
    logic                   we_mux;
    logic [SEL_W-1:0]       sel_mux;
    logic [ADR_W-1:0]       adr_mux;
    logic [DAT_W-1:0]       dat_mux;

    function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [NUM_MASTERS-1:0] oh);
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (oh[i]) begin
                idx = idx | PTR_W'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_MASTERS - 1)) ? '0 : p + 1'b1;
    endfunction

    wb_rr_pick #(
        .NUM_MASTERS (NUM_MASTERS)
    ) u_pick (
        .req    (bus.m_cyc_i),
        .rr_ptr (rr_ptr_q),
        .gnt    (pick_gnt),
        .vld    (pick_vld)
    );

    assign busy    = (state_q == WB_ARB_BUSY);
    assign own_cyc = bus.m_cyc_i[owner_q];
    assign own_stb = bus.m_stb_i[owner_q];

    // Owner mux; everything is zero outside BUSY so IDLE and ERR present a
    // quiet bus to the slave.
    always_comb begin
        cyc_mux = 1'b0;
        stb_mux = 1'b0;
        we_mux  = 1'b0;
        sel_mux = '0;
        adr_mux = '0;
        dat_mux = '0;
        if (busy) begin
            cyc_mux = own_cyc;
            stb_mux = own_cyc & own_stb;
            for (int k = 0; k < NUM_MASTERS; k++) begin
                if (owner_q == PTR_W'(k)) begin
                    we_mux  = bus.m_we_i[k];
                    sel_mux = bus.m_sel_i[k*SEL_W +: SEL_W];
                    adr_mux = bus.m_adr_i[k*ADR_W +: ADR_W];
                    dat_mux = bus.m_dat_i[k*DAT_W +: DAT_W];
                end
            end
        end
    end

    assign bus.cyc_o   = cyc_mux;
    assign bus.stb_o   = stb_mux;
    assign bus.we_o    = we_mux;
    assign bus.sel_o   = sel_mux;
    assign bus.adr_o   = adr_mux;
    assign bus.dat_o   = dat_mux;
    assign bus.gnt_o   = gnt_q;
    assign bus.m_dat_o = bus.dat_i;

    // Ack/err are gated by rst_i so a slave ack landing on the reset cycle is
    // never seen by the owner, even though the state is still BUSY then.
    assign bus.m_ack_o = (rst_i && busy && bus.ack_i && stb_mux) ? gnt_q : '0;
    assign bus.m_err_o = (rst_i && state_q == WB_ARB_ERR) ? gnt_q : '0;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q  <= WB_ARB_IDLE;
            gnt_q    <= '0;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            wd_cnt_q <= '0;
        end else begin
            unique case (state_q)
                WB_ARB_IDLE: begin
                    wd_cnt_q <= '0;
                    if (pick_vld) begin
                        gnt_q   <= pick_gnt;
                        owner_q <= onehot_to_idx(pick_gnt);
                        state_q <= WB_ARB_BUSY;
                    end
                end
                WB_ARB_BUSY: begin
                    if (!own_cyc) begin
                        state_q  <= WB_ARB_IDLE;
                        gnt_q    <= '0;
                        rr_ptr_q <= next_ptr(owner_q);
                        wd_cnt_q <= '0;
                    end else if (bus.ack_i) begin
                        // An ack on the expiry cycle lands here first: ack wins.
                        wd_cnt_q <= '0;
                    end else if (stb_mux) begin
                        if (wd_cnt_q == CNT_W'(TIMEOUT)) begin
                            state_q  <= WB_ARB_ERR;
                            wd_cnt_q <= '0;
                        end else begin
                            wd_cnt_q <= wd_cnt_q + 1'b1;
                        end
                    end
                end
                WB_ARB_ERR: begin
                    state_q  <= WB_ARB_IDLE;
                    gnt_q    <= '0;
                    rr_ptr_q <= next_ptr(owner_q);
                end
                default: begin
                    state_q <= WB_ARB_IDLE;
                    gnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
module tb_wb_rr_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst_i;

    always #5 clk = ~clk;

    wb_rr_arbiter_if #(.NUM_MASTERS(N), .ADR_W(AW), .DAT_W(DW), .SEL_W(SW)) bus ();

    wb_rr_arbiter #(
        .NUM_MASTERS (N),
        .ADR_W       (AW),
        .DAT_W       (DW),
        .SEL_W       (SW),
        .TIMEOUT     (TO)
    ) dut (
        .clk_i (clk),
        .rst_i (rst_i),
        .bus   (bus)
    );

    typedef struct {
        int          idx;
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
    } txn_t;

    txn_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic drive_master(input int k, input logic cyc, input logic stb, input logic we,
                                input logic [31:0] adr, input logic [31:0] dat);
        bus.m_cyc_i[k]            = cyc;
        bus.m_stb_i[k]            = stb;
        bus.m_we_i[k]             = we;
        bus.m_adr_i[k*AW +: AW]   = adr;
        bus.m_dat_i[k*DW +: DW]   = dat;
        bus.m_sel_i[k*SW +: SW]   = 4'hF;
    endtask

    task automatic clear_inputs();
        bus.m_cyc_i = '0;
        bus.m_stb_i = '0;
        bus.m_we_i  = '0;
        bus.m_sel_i = '0;
        bus.m_adr_i = '0;
        bus.m_dat_i = '0;
        bus.ack_i   = 1'b0;
        bus.dat_i   = '0;
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        clear_inputs();
        drive_master(0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
        bus.ack_i = 1'b1;
        bus.dat_i = 32'h1234_5678;
        step();
        step();
        settle();
        checks++; if (bus.gnt_o !== 4'b0) begin errors++; $display("FAIL reset_gnt got %b exp %b", bus.gnt_o, 4'b0); end
        checks++; if (bus.cyc_o !== 1'b0 || bus.stb_o !== 1'b0) begin errors++; $display("FAIL reset_cycstb got %b%b exp 00", bus.cyc_o, bus.stb_o); end
        checks++; if (bus.adr_o !== 32'h0 || bus.dat_o !== 32'h0) begin errors++; $display("FAIL reset_adrdat got %h/%h exp 0/0", bus.adr_o, bus.dat_o); end
        checks++; if (bus.m_ack_o !== 4'b0 || bus.m_err_o !== 4'b0) begin errors++; $display("FAIL reset_ackerr got %b/%b exp 0000/0000", bus.m_ack_o, bus.m_err_o); end
        checks++; if (bus.m_dat_o !== 32'h1234_5678) begin errors++; $display("FAIL m_dat_pass got %h exp %h", bus.m_dat_o, 32'h1234_5678); end
        clear_inputs();
        rst_i = 1'b1;
        step();
        settle();
        checks++; if (bus.gnt_o !== 4'b0) begin errors++; $display("FAIL idle_gnt got %b exp %b", bus.gnt_o, 4'b0); end
    endtask

    task automatic test_fairness();
        logic [3:0] ack_seen;
        logic [3:0] prev_gnt;
        logic [3:0] exp_g;
        int         acks [4];
        bit         done;
        txn_t       t;
        for (int k = 0; k < 2; k++) begin
            sb_q.push_back('{0, 1'b0, 32'h0000_0000, 32'h0});
            sb_q.push_back('{1, 1'b0, 32'h0000_0100, 32'h0});
            sb_q.push_back('{3, 1'b0, 32'h0000_0300, 32'h0});
        end
        ack_seen = '0;
        prev_gnt = '0;
        for (int k = 0; k < 4; k++) acks[k] = 0;
        done = 1'b0;
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            step();
            for (int k = 0; k < 4; k++) begin
                if (k != 2) begin
                    drive_master(k, (acks[k] < 2) && !ack_seen[k], (acks[k] < 2) && !ack_seen[k],
                                 1'b0, 32'h100 * k, 32'h0);
                end
            end
            bus.ack_i = |(bus.gnt_o & bus.m_cyc_i);
            bus.dat_i = 32'hC0DE_0000 + cyc;
            settle();
            ack_seen = bus.m_ack_o;
            for (int k = 0; k < 4; k++) if (ack_seen[k]) acks[k]++;
            if (bus.gnt_o !== 4'b0 && bus.gnt_o !== prev_gnt) begin
                if (sb_q.size() == 0) begin
                    checks++; errors++; $display("FAIL fair_extra_grant got %b exp none", bus.gnt_o);
                end else begin
                    t = sb_q.pop_front();
                    exp_g = 4'b0001 << t.idx;
                    checks++; if (bus.gnt_o !== exp_g) begin errors++; $display("FAIL fair_order got %b exp %b", bus.gnt_o, exp_g); end
                    checks++; if (bus.adr_o !== t.adr) begin errors++; $display("FAIL fair_adr got %h exp %h", bus.adr_o, t.adr); end
                    checks++; if (prev_gnt !== 4'b0) begin errors++; $display("FAIL fair_idle_gap got %b exp %b", prev_gnt, 4'b0); end
                end
            end
            prev_gnt = bus.gnt_o;
            done = (acks[0] == 2) && (acks[1] == 2) && (acks[3] == 2);
        end
        checks++; if (!done) begin errors++; $display("FAIL fair_timeout got acks %0d/%0d/%0d exp 2/2/2", acks[0], acks[1], acks[3]); end
        checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL fair_left got %0d exp 0", sb_q.size()); end
        sb_q.delete();
        clear_inputs();
        step();
        step();
    endtask

    task automatic test_single();
        txn_t t;
        step();
        drive_master(2, 1'b1, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
        sb_q.push_back('{2, 1'b1, 32'h10, 32'hDEAD_BEEF});
        settle();
        checks++; if (bus.gnt_o !== 4'b0) begin errors++; $display("FAIL single_early got %b exp %b", bus.gnt_o, 4'b0); end
        step();
        settle();
        t = sb_q.pop_front();
        checks++; if (bus.gnt_o !== 4'b0100) begin errors++; $display("FAIL single_gnt got %b exp %b", bus.gnt_o, 4'b0100); end
        checks++; if (bus.adr_o !== t.adr || bus.dat_o !== t.dat) begin errors++; $display("FAIL single_adrdat got %h/%h exp %h/%h", bus.adr_o, bus.dat_o, t.adr, t.dat); end
        checks++; if (bus.we_o !== t.we || bus.cyc_o !== 1'b1 || bus.stb_o !== 1'b1) begin errors++; $display("FAIL single_ctl got we%b cyc%b stb%b exp 111", bus.we_o, bus.cyc_o, bus.stb_o); end
        checks++; if (bus.sel_o !== 4'hF) begin errors++; $display("FAIL single_sel got %h exp %h", bus.sel_o, 4'hF); end
        for (int i = 0; i < 2; i++) begin
            step();
            settle();
            checks++; if (bus.m_ack_o !== 4'b0) begin errors++; $display("FAIL single_noack got %b exp %b", bus.m_ack_o, 4'b0); end
        end
        step();
        bus.ack_i = 1'b1;
        settle();
        checks++; if (bus.m_ack_o !== 4'b0100) begin errors++; $display("FAIL single_ack got %b exp %b", bus.m_ack_o, 4'b0100); end
        step();
        bus.ack_i = 1'b0;
        drive_master(2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        settle();
        checks++; if (bus.m_ack_o !== 4'b0 || bus.cyc_o !== 1'b0) begin errors++; $display("FAIL single_ack_once got ack%b cyc%b exp 0000 0", bus.m_ack_o, bus.cyc_o); end
        step();
        settle();
        checks++; if (bus.gnt_o !== 4'b0 || bus.cyc_o !== 1'b0) begin errors++; $display("FAIL single_idle got gnt%b cyc%b exp 0000 0", bus.gnt_o, bus.cyc_o); end
    endtask

    task automatic test_burst();
        int         beats1;
        bit         done0;
        logic [3:0] prev_gnt;
        logic [3:0] exp_g;
        txn_t       t;
        beats1   = 0;
        done0    = 1'b0;
        prev_gnt = '0;
        sb_q.push_back('{1, 1'b0, 32'h2000, 32'h0});
        sb_q.push_back('{0, 1'b1, 32'h3000, 32'h55});
        step();
        drive_master(1, 1'b1, 1'b1, 1'b0, 32'h2000, 32'h0);
        settle();
        for (int i = 0; i < 30 && !done0; i++) begin
            step();
            drive_master(0, !done0, !done0, 1'b1, 32'h3000, 32'h55);
            drive_master(1, beats1 < 4, beats1 < 4, 1'b0, 32'h2000, 32'h0);
            bus.ack_i = |(bus.gnt_o & bus.m_cyc_i & bus.m_stb_i);
            bus.dat_i = 32'hA5A5_0000 + i;
            settle();
            if (bus.m_cyc_i[1]) begin
                checks++; if (bus.gnt_o !== 4'b0010 || bus.m_ack_o[0] !== 1'b0) begin errors++; $display("FAIL burst_hold got gnt%b ack%b exp 0010 xxx0", bus.gnt_o, bus.m_ack_o); end
            end
            if (bus.m_ack_o[1]) begin
                beats1++;
                checks++; if (bus.m_dat_o !== bus.dat_i) begin errors++; $display("FAIL burst_rdata got %h exp %h", bus.m_dat_o, bus.dat_i); end
            end
            if (bus.m_ack_o[0]) done0 = 1'b1;
            if (bus.gnt_o !== 4'b0 && bus.gnt_o !== prev_gnt) begin
                if (sb_q.size() == 0) begin
                    checks++; errors++; $display("FAIL burst_extra_grant got %b exp none", bus.gnt_o);
                end else begin
                    t = sb_q.pop_front();
                    exp_g = 4'b0001 << t.idx;
                    checks++; if (bus.gnt_o !== exp_g || bus.adr_o !== t.adr || bus.we_o !== t.we) begin errors++; $display("FAIL burst_grant got %b/%h/%b exp %b/%h/%b", bus.gnt_o, bus.adr_o, bus.we_o, exp_g, t.adr, t.we); end
                    checks++; if (prev_gnt !== 4'b0) begin errors++; $display("FAIL burst_idle_gap got %b exp %b", prev_gnt, 4'b0); end
                end
            end
            prev_gnt = bus.gnt_o;
        end
        checks++; if (beats1 != 4 || !done0) begin errors++; $display("FAIL burst_beats got %0d/%0d exp 4/1", beats1, done0); end
        checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL burst_left got %0d exp 0", sb_q.size()); end
        sb_q.delete();
        clear_inputs();
        step();
        step();
    endtask

    task automatic test_timeout();
        int         err_first;
        int         err_cycles;
        int         g2_cycle;
        logic [3:0] err_val;
        logic       cyc_at_err;
        bit         err_seen0;
        bit         got2;
        bit         ack0_any;
        logic [3:0] prev_gnt;
        logic [3:0] exp_g;
        txn_t       t;
        err_first = -1; err_cycles = 0; g2_cycle = -1; err_val = '0; cyc_at_err = 1'bx;
        err_seen0 = 1'b0; got2 = 1'b0; ack0_any = 1'b0; prev_gnt = '0;
        sb_q.push_back('{0, 1'b0, 32'h4000, 32'h0});
        sb_q.push_back('{2, 1'b1, 32'h5000, 32'h77});
        step();
        drive_master(0, 1'b1, 1'b1, 1'b0, 32'h4000, 32'h0);
        settle();
        for (int i = 0; i < 15; i++) begin
            step();
            drive_master(0, !err_seen0, !err_seen0, 1'b0, 32'h4000, 32'h0);
            if (i >= 1) drive_master(2, !got2, !got2, 1'b1, 32'h5000, 32'h77);
            bus.ack_i = (bus.gnt_o == 4'b0100) && bus.m_cyc_i[2];
            settle();
            if (i == 0) begin
                checks++; if (bus.stb_o !== 1'b1) begin errors++; $display("FAIL to_stb_rise got %b exp 1", bus.stb_o); end
            end
            if (bus.m_err_o !== 4'b0) begin
                if (err_first < 0) begin
                    err_first  = i;
                    err_val    = bus.m_err_o;
                    cyc_at_err = bus.cyc_o;
                end
                err_cycles++;
            end
            if (bus.m_err_o[0]) err_seen0 = 1'b1;
            if (bus.m_ack_o[0]) ack0_any = 1'b1;
            if (bus.m_ack_o[2]) got2 = 1'b1;
            if (bus.gnt_o !== 4'b0 && bus.gnt_o !== prev_gnt && sb_q.size() != 0) begin
                t = sb_q.pop_front();
                exp_g = 4'b0001 << t.idx;
                checks++; if (bus.gnt_o !== exp_g || bus.adr_o !== t.adr) begin errors++; $display("FAIL to_grant got %b/%h exp %b/%h", bus.gnt_o, bus.adr_o, exp_g, t.adr); end
                if (t.idx == 2) g2_cycle = i;
            end
            prev_gnt = bus.gnt_o;
        end
        checks++; if (err_first != 9) begin errors++; $display("FAIL to_err_cycle got %0d exp %0d", err_first, 9); end
        checks++; if (err_val !== 4'b0001) begin errors++; $display("FAIL to_err_val got %b exp %b", err_val, 4'b0001); end
        checks++; if (cyc_at_err !== 1'b0) begin errors++; $display("FAIL to_err_cyc got %b exp 0", cyc_at_err); end
        checks++; if (err_cycles != 1) begin errors++; $display("FAIL to_err_width got %0d exp 1", err_cycles); end
        checks++; if (ack0_any) begin errors++; $display("FAIL to_no_ack got 1 exp 0"); end
        checks++; if (g2_cycle != 11 || !got2) begin errors++; $display("FAIL to_next_served got %0d/%0d exp 11/1", g2_cycle, got2); end
        sb_q.delete();
        clear_inputs();
        step();
        step();
    endtask

    task automatic test_ack_expiry();
        int err_first;
        bit err_seen1;
        err_first = -1;
        err_seen1 = 1'b0;
        step();
        drive_master(1, 1'b1, 1'b1, 1'b0, 32'h6000, 32'h0);
        settle();
        for (int i = 0; i < 21; i++) begin
            step();
            drive_master(1, !err_seen1, !err_seen1, 1'b0, 32'h6000, 32'h0);
            bus.ack_i = (i == 8);
            settle();
            if (i == 8) begin
                checks++; if (bus.m_ack_o !== 4'b0010 || bus.m_err_o !== 4'b0) begin errors++; $display("FAIL exp_ack got ack%b err%b exp 0010 0000", bus.m_ack_o, bus.m_err_o); end
            end
            if (i == 9) begin
                checks++; if (bus.gnt_o !== 4'b0010 || bus.cyc_o !== 1'b1 || bus.m_err_o !== 4'b0) begin errors++; $display("FAIL exp_stay_busy got gnt%b cyc%b err%b exp 0010 1 0000", bus.gnt_o, bus.cyc_o, bus.m_err_o); end
            end
            if (bus.m_err_o !== 4'b0 && err_first < 0) err_first = i;
            if (bus.m_err_o[1]) err_seen1 = 1'b1;
        end
        checks++; if (err_first != 18) begin errors++; $display("FAIL exp_restart got %0d exp %0d", err_first, 18); end
        clear_inputs();
        step();
        step();
    endtask

    task automatic test_reset_mid();
        step();
        drive_master(3, 1'b1, 1'b1, 1'b1, 32'h7000, 32'h99);
        settle();
        step();
        settle();
        checks++; if (bus.gnt_o !== 4'b1000) begin errors++; $display("FAIL rm_gnt3 got %b exp %b", bus.gnt_o, 4'b1000); end
        step();
        rst_i     = 1'b0;
        bus.ack_i = 1'b1;
        settle();
        checks++; if (bus.m_ack_o !== 4'b0 || bus.m_err_o !== 4'b0) begin errors++; $display("FAIL rm_no_ack got ack%b err%b exp 0000 0000", bus.m_ack_o, bus.m_err_o); end
        step();
        rst_i     = 1'b1;
        bus.ack_i = 1'b0;
        drive_master(1, 1'b1, 1'b1, 1'b0, 32'h8000, 32'h0);
        settle();
        checks++; if (bus.gnt_o !== 4'b0 || bus.cyc_o !== 1'b0 || bus.stb_o !== 1'b0) begin errors++; $display("FAIL rm_cleared got gnt%b cyc%b stb%b exp 0000 0 0", bus.gnt_o, bus.cyc_o, bus.stb_o); end
        checks++; if (bus.adr_o !== 32'h0 || bus.we_o !== 1'b0 || bus.m_ack_o !== 4'b0) begin errors++; $display("FAIL rm_outs got adr%h we%b ack%b exp 0 0 0000", bus.adr_o, bus.we_o, bus.m_ack_o); end
        step();
        settle();
        checks++; if (bus.gnt_o !== 4'b0010) begin errors++; $display("FAIL rm_scan_from0 got %b exp %b", bus.gnt_o, 4'b0010); end
        clear_inputs();
        step();
        step();
    endtask

    initial begin
        rst_i = 1'b0;
        clear_inputs();
        test_reset();
        test_fairness();
        test_single();
        test_burst();
        test_timeout();
        test_ack_expiry();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
- Round-robin arbiter that shares one Wishbone slave bus among NUM_MASTERS wishbone_master instances.
- Sits between the masters and the slave interconnect.
- Grants whole bus cycles (held while the owner's cyc is high), muxes the owner's signals to the slave and routes ack back.
- A watchdog aborts a transfer that stalls without ack.

Parameters:
- NUM_MASTERS, 4, number of requesters (2..8).
- ADR_W, 32, address width.
- DAT_W, 32, data width.
- SEL_W, 4, byte-select width.
- TIMEOUT, 255, max cycles stb may wait for ack before abort (1..65535).

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_i  in  1  synchronous reset, active-low.
- m_cyc_i  in  NUM_MASTERS  per-master cyc.
- m_stb_i  in  NUM_MASTERS  per-master stb.
- m_we_i  in  NUM_MASTERS  per-master write enable.
- m_sel_i  in  NUM_MASTERS*SEL_W  packed selects; master k at [k*SEL_W +: SEL_W].
- m_adr_i  in  NUM_MASTERS*ADR_W  packed addresses.
- m_dat_i  in  NUM_MASTERS*DAT_W  packed write data.
- m_ack_o  out  NUM_MASTERS  per-master ack.
- m_err_o  out  NUM_MASTERS  per-master timeout error pulse.
- m_dat_o  out  DAT_W  read data, broadcast to all masters.
- gnt_o  out  NUM_MASTERS  one-hot current grant (registered).
- cyc_o, stb_o, we_o  out  1  slave-side controls.
- sel_o  out  SEL_W  slave-side select.
- adr_o  out  ADR_W  slave-side address.
- dat_o  out  DAT_W  slave-side write data.
- ack_i  in  1  slave ack.
- dat_i  in  DAT_W  slave read data.

Behaviour:
- Reset (rst_i==0 at a clock edge) takes effect that edge:
  - state=IDLE, gnt_o=0, rr_ptr=0, timeout counter=0.
  - All slave outputs 0; m_ack_o=0, m_err_o=0.
  - Reset mid-transfer drops cyc_o at the next edge; no ack or err is forwarded.
- States:
  - IDLE: gnt_o=0, all slave outputs 0.
    - If any m_cyc_i is high, pick the first requester k scanning rr_ptr, rr_ptr+1, ... mod NUM_MASTERS.
    - Register gnt_o=onehot(k) and go to BUSY.
    - Latency: request sampled at edge N, cyc_o high after edge N.
  - BUSY: slave outputs are a combinational mux of master g (the gnt_o index). cyc_o=m_cyc_i[g], stb_o=m_cyc_i[g]&m_stb_i[g].
    - m_ack_o[g]=ack_i&stb_o; all other ack bits are 0.
    - Stay in BUSY while m_cyc_i[g]=1; this supports multi-beat bursts.
    - When m_cyc_i[g]=0: go to IDLE, set rr_ptr=(g+1) mod NUM_MASTERS, clear gnt_o.
    - There is always one idle cycle between owners.
  - ERR: one cycle. m_err_o[g]=1, cyc_o=stb_o=0, m_ack_o=0. Then IDLE, with rr_ptr=(g+1) mod N.
- Watchdog:
  - In BUSY, count cycles with stb_o=1 and ack_i=0.
  - Counter clears on ack_i and on leaving BUSY.
  - When the count reaches TIMEOUT with no ack that cycle, go to ERR.
  - Ack on the same cycle as expiry: ack wins, no error.
- m_dat_o=dat_i always (unregistered); masters qualify it with their own ack.
- Ack or dat from the slave while IDLE or in ERR is ignored and never forwarded.
- Requests from non-granted masters are held off (no ack) with no side effect.
- Masters must keep cyc high until their grant arrives.
- m_cyc_i of the owner dropping in the same cycle as ack_i: ack is forwarded, then IDLE.
- Counter width is clog2(TIMEOUT+1); no wrap is possible.

Decomposition:
- Shared package wb_pkg holds:
  - state encoding constants (WB_ARB_IDLE, WB_ARB_BUSY, WB_ARB_ERR);
  - the default ADR_W, DAT_W and SEL_W values, also used by wishbone_master.
- One sub-module, wb_rr_pick: combinational round-robin priority picker. Inputs are the request vector and rr_ptr; outputs are a one-hot grant and a valid flag.
- The state machine, mux and watchdog stay in wb_rr_arbiter.

Test Plan:
1. Single requester: master 2 raises cyc/stb, we=1, adr=0x10, dat=0xDEADBEEF; slave acks 3 cycles later.
   - Expect gnt_o=0100 one cycle after the request, and the slave sees adr 0x10, dat 0xDEADBEEF, we=1.
   - Expect m_ack_o[2] for exactly one cycle.
   - Expect the bus idle one cycle after cyc drops.
2. Fairness: masters 0, 1, 3 request continuously, each dropping cyc after one ack; slave acks immediately.
   - Expect grant order 0, 1, 3, 0, 1, 3 with one IDLE cycle between each.
3. Burst: master 1 holds cyc for 4 stb/ack beats while master 0 also requests.
   - Master 1 keeps the grant through all 4 acks; master 0 is granted only after master 1's cyc falls.
4. Timeout: TIMEOUT=8, master 0 strobes and the slave never acks.
   - Expect m_err_o[0] for one cycle, 9 cycles after stb_o rose; cyc_o low in that cycle; the next requester is then served.
5. Ack at expiry: slave acks on exactly the TIMEOUT-th waiting cycle.
   - Expect m_ack_o set, m_err_o=0, state stays BUSY.
6. Reset mid-transfer: rst_i=0 for one cycle while master 3 is mid-BUSY and the slave acks the same cycle.
   - Expect all outputs 0 and gnt_o=0 after that edge, no ack forwarded, and the next grant scan starting at master 0.
